// File: rtl/rf_operand_fetch.sv
// Operand fetch stage: register-file read, pending-write scoreboard, hazard stall and output register.
// Define OPFETCH_BYPASS_EN to forward same-cycle writeback data into the operands.
module rf_operand_fetch #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [7:0]        IN_OPCODE,
    input  logic [ADDR_W-1:0] IN_RA,
    input  logic [ADDR_W-1:0] IN_RB,
    input  logic [ADDR_W-1:0] IN_RC,
    input  logic [ADDR_W-1:0] IN_RD,
    input  logic              IN_WEN,
    output logic [ADDR_W-1:0] ADDRA,
    output logic [ADDR_W-1:0] ADDRB,
    output logic [ADDR_W-1:0] ADDRC,
    input  logic [DATA_W-1:0] DOA,
    input  logic [DATA_W-1:0] DOB,
    input  logic [DATA_W-1:0] DOC,
    input  logic              WB_WE,
    input  logic [ADDR_W-1:0] WB_ADDR,
    input  logic [DATA_W-1:0] WB_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [7:0]        OUT_OPCODE,
    output logic [DATA_W-1:0] OUT_A,
    output logic [DATA_W-1:0] OUT_B,
    output logic [DATA_W-1:0] OUT_C,
    output logic [ADDR_W-1:0] OUT_RD,
    output logic              OUT_WEN,
    output logic [15:0]       STALL_CNT
);
    localparam int NREG = 1 << ADDR_W;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [NREG-1:0]   pending_q, pending_d, set_vec, clr_vec;
    logic [15:0]       stall_cnt_q, stall_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_opcode_q, out_opcode_d;
    logic [DATA_W-1:0] out_a_q, out_a_d, out_b_q, out_b_d, out_c_q, out_c_d;
    logic [ADDR_W-1:0] out_rd_q, out_rd_d;
    logic              out_wen_q, out_wen_d;
    logic              raw_a, raw_b, raw_c, raw, waw, hazard, accept;
    logic [DATA_W-1:0] opa, opb, opc;

    assign ADDRA = IN_RA;
    assign ADDRB = IN_RB;
    assign ADDRC = IN_RC;

`ifdef OPFETCH_BYPASS_EN
    logic hit_a, hit_b, hit_c;
    assign hit_a = WB_WE && (WB_ADDR == IN_RA);
    assign hit_b = WB_WE && (WB_ADDR == IN_RB);
    assign hit_c = WB_WE && (WB_ADDR == IN_RC);
    // The RF read port still shows the pre-write value, so forward WB_DATA on a match.
    assign raw_a = pending_q[IN_RA] && !hit_a;
    assign raw_b = pending_q[IN_RB] && !hit_b;
    assign raw_c = pending_q[IN_RC] && !hit_c;
    assign opa   = hit_a ? WB_DATA : DOA;
    assign opb   = hit_b ? WB_DATA : DOB;
    assign opc   = hit_c ? WB_DATA : DOC;
`else
    assign raw_a = pending_q[IN_RA];
    assign raw_b = pending_q[IN_RB];
    assign raw_c = pending_q[IN_RC];
    assign opa   = DOA;
    assign opb   = DOB;
    assign opc   = DOC;
`endif

    always_comb begin
        clr_vec = '0;
        if (WB_WE) clr_vec[WB_ADDR] = 1'b1;
        raw      = raw_a || raw_b || raw_c;
        waw      = IN_WEN && pending_q[IN_RD] && !(WB_WE && (WB_ADDR == IN_RD));
        hazard   = raw || waw;
        IN_READY = (!out_valid_q || OUT_READY) && !hazard;
        accept   = IN_VALID && IN_READY;
        set_vec  = '0;
        if (accept && IN_WEN) set_vec[IN_RD] = 1'b1;
        // Set after clear so a new writer of the same register keeps it pending.
        pending_d   = (pending_q & ~clr_vec) | set_vec;
        stall_cnt_d = (IN_VALID && hazard) ? sat_inc(stall_cnt_q) : stall_cnt_q;

        out_valid_d  = out_valid_q;
        out_opcode_d = out_opcode_q;
        out_a_d      = out_a_q;
        out_b_d      = out_b_q;
        out_c_d      = out_c_q;
        out_rd_d     = out_rd_q;
        out_wen_d    = out_wen_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_opcode_d = IN_OPCODE;
            out_a_d      = opa;
            out_b_d      = opb;
            out_c_d      = opc;
            out_rd_d     = IN_RD;
            out_wen_d    = IN_WEN;
        end else if (OUT_READY) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pending_q    <= '0;
            stall_cnt_q  <= '0;
            out_valid_q  <= 1'b0;
            out_opcode_q <= '0;
            out_a_q      <= '0;
            out_b_q      <= '0;
            out_c_q      <= '0;
            out_rd_q     <= '0;
            out_wen_q    <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            stall_cnt_q  <= stall_cnt_d;
            out_valid_q  <= out_valid_d;
            out_opcode_q <= out_opcode_d;
            out_a_q      <= out_a_d;
            out_b_q      <= out_b_d;
            out_c_q      <= out_c_d;
            out_rd_q     <= out_rd_d;
            out_wen_q    <= out_wen_d;
        end
    end

    assign OUT_VALID  = out_valid_q;
    assign OUT_OPCODE = out_opcode_q;
    assign OUT_A      = out_a_q;
    assign OUT_B      = out_b_q;
    assign OUT_C      = out_c_q;
    assign OUT_RD     = out_rd_q;
    assign OUT_WEN    = out_wen_q;
    assign STALL_CNT  = stall_cnt_q;
endmodule

// File: tb/tb_rf_operand_fetch.sv
// Directed bench for rf_operand_fetch with a behavioural register file on the read/write ports.
module tb_rf_operand_fetch;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [7:0]  IN_OPCODE = '0;
    logic [4:0]  IN_RA = '0, IN_RB = '0, IN_RC = '0, IN_RD = '0;
    logic        IN_WEN = 1'b0;
    logic [4:0]  ADDRA, ADDRB, ADDRC;
    logic [15:0] DOA, DOB, DOC;
    logic        WB_WE = 1'b0;
    logic [4:0]  WB_ADDR = '0;
    logic [15:0] WB_DATA = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;
    logic [7:0]  OUT_OPCODE;
    logic [15:0] OUT_A, OUT_B, OUT_C;
    logic [4:0]  OUT_RD;
    logic        OUT_WEN;
    logic [15:0] STALL_CNT;

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0] rf [32];

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (WB_WE) rf[WB_ADDR] <= WB_DATA;
    assign DOA = rf[ADDRA];
    assign DOB = rf[ADDRB];
    assign DOC = rf[ADDRC];

    rf_operand_fetch #(.DATA_W(16), .ADDR_W(5)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_OPCODE(IN_OPCODE),
        .IN_RA(IN_RA), .IN_RB(IN_RB), .IN_RC(IN_RC), .IN_RD(IN_RD), .IN_WEN(IN_WEN),
        .ADDRA(ADDRA), .ADDRB(ADDRB), .ADDRC(ADDRC),
        .DOA(DOA), .DOB(DOB), .DOC(DOC),
        .WB_WE(WB_WE), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_OPCODE(OUT_OPCODE),
        .OUT_A(OUT_A), .OUT_B(OUT_B), .OUT_C(OUT_C),
        .OUT_RD(OUT_RD), .OUT_WEN(OUT_WEN), .STALL_CNT(STALL_CNT)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        IN_VALID = 1'b0; IN_WEN = 1'b0; WB_WE = 1'b0; OUT_READY = 1'b1;
        IN_RA = '0; IN_RB = '0; IN_RC = '0; IN_RD = '0; IN_OPCODE = '0;
    endtask

    task automatic do_reset();
        idle();
        RST_N = 1'b0;
        #2;
        RST_N = 1'b1;
    endtask

    task automatic issue(input logic [7:0] op, input logic [4:0] ra, input logic [4:0] rb,
                         input logic [4:0] rd, input logic wen);
        IN_VALID = 1'b1; IN_OPCODE = op; IN_RA = ra; IN_RB = rb; IN_RC = 5'd0;
        IN_RD = rd; IN_WEN = wen;
    endtask

    task automatic rf_write(input logic [4:0] a, input logic [15:0] d);
        WB_WE = 1'b1; WB_ADDR = a; WB_DATA = d;
        step();
        WB_WE = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        RST_N = 1'b0;
        #1;
        tests_run++;
        if (OUT_VALID !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", OUT_VALID); end
        tests_run++;
        if (STALL_CNT !== 16'h0) begin tests_failed++; $display("FAIL reset_stall_cnt: got %h expected 0000", STALL_CNT); end
        tests_run++;
        if (OUT_A !== 16'h0) begin tests_failed++; $display("FAIL reset_out_a: got %h expected 0000", OUT_A); end
        RST_N = 1'b1;
        step();
        rf_write(5'd0, 16'h0000);
        rf_write(5'd3, 16'h0011);
        rf_write(5'd4, 16'h0022);
    endtask

    task automatic test_basic();
        do_reset();
        step();
        issue(8'hA5, 5'd3, 5'd4, 5'd1, 1'b0);
        #1;
        tests_run++;
        if (ADDRA !== 5'd3 || ADDRB !== 5'd4) begin tests_failed++; $display("FAIL basic_addr: got %0d/%0d expected 3/4", ADDRA, ADDRB); end
        tests_run++;
        if (IN_READY !== 1'b1) begin tests_failed++; $display("FAIL basic_in_ready: got %b expected 1", IN_READY); end
        step();
        IN_VALID = 1'b0;
        tests_run++;
        if (OUT_VALID !== 1'b1 || OUT_A !== 16'h0011 || OUT_B !== 16'h0022)
            begin tests_failed++; $display("FAIL basic_bundle: got v=%b a=%h b=%h expected v=1 a=0011 b=0022", OUT_VALID, OUT_A, OUT_B); end
        tests_run++;
        if (OUT_OPCODE !== 8'hA5 || OUT_RD !== 5'd1 || STALL_CNT !== 16'h0)
            begin tests_failed++; $display("FAIL basic_fields: got op=%h rd=%0d stall=%h expected A5/1/0000", OUT_OPCODE, OUT_RD, STALL_CNT); end
        step();
        tests_run++;
        if (OUT_VALID !== 1'b0) begin tests_failed++; $display("FAIL basic_drain: got %b expected 0", OUT_VALID); end
    endtask

    task automatic test_raw();
        logic [15:0] exp_stall;
        do_reset();
        step();
        issue(8'h01, 5'd0, 5'd0, 5'd5, 1'b1);
        step();
        tests_run++;
        if (OUT_VALID !== 1'b1 || OUT_RD !== 5'd5 || OUT_WEN !== 1'b1)
            begin tests_failed++; $display("FAIL raw_i1: got v=%b rd=%0d wen=%b expected 1/5/1", OUT_VALID, OUT_RD, OUT_WEN); end
        issue(8'h02, 5'd5, 5'd0, 5'd6, 1'b0);
        #1;
        tests_run++;
        if (IN_READY !== 1'b0) begin tests_failed++; $display("FAIL raw_stall_ready: got %b expected 0", IN_READY); end
        step();
        step();
        tests_run++;
        if (STALL_CNT !== 16'd2) begin tests_failed++; $display("FAIL raw_stall_cnt: got %h expected 0002", STALL_CNT); end
        WB_WE = 1'b1; WB_ADDR = 5'd5; WB_DATA = 16'h1234;
        #1;
`ifdef OPFETCH_BYPASS_EN
        exp_stall = 16'd2;
        tests_run++;
        if (IN_READY !== 1'b1) begin tests_failed++; $display("FAIL raw_bypass_ready: got %b expected 1", IN_READY); end
        step();
        WB_WE = 1'b0;
`else
        exp_stall = 16'd3;
        tests_run++;
        if (IN_READY !== 1'b0) begin tests_failed++; $display("FAIL raw_wb_cycle_ready: got %b expected 0", IN_READY); end
        step();
        WB_WE = 1'b0;
        #1;
        tests_run++;
        if (IN_READY !== 1'b1) begin tests_failed++; $display("FAIL raw_after_wb_ready: got %b expected 1", IN_READY); end
        step();
`endif
        IN_VALID = 1'b0;
        tests_run++;
        if (OUT_VALID !== 1'b1 || OUT_A !== 16'h1234 || OUT_OPCODE !== 8'h02)
            begin tests_failed++; $display("FAIL raw_operand: got v=%b a=%h op=%h expected 1/1234/02", OUT_VALID, OUT_A, OUT_OPCODE); end
        tests_run++;
        if (STALL_CNT !== exp_stall) begin tests_failed++; $display("FAIL raw_stall_final: got %h expected %h", STALL_CNT, exp_stall); end
    endtask

    task automatic test_backpressure();
        do_reset();
        step();
        OUT_READY = 1'b0;
        issue(8'h11, 5'd3, 5'd4, 5'd2, 1'b0);
        step();
        issue(8'h22, 5'd4, 5'd3, 5'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1 || OUT_OPCODE !== 8'h11 || OUT_A !== 16'h0011 || OUT_B !== 16'h0022)
                begin tests_failed++; $display("FAIL bp_hold[%0d]: got rdy=%b v=%b op=%h a=%h b=%h expected 0/1/11/0011/0022",
                                               i, IN_READY, OUT_VALID, OUT_OPCODE, OUT_A, OUT_B); end
            step();
        end
        OUT_READY = 1'b1;
        #1;
        tests_run++;
        if (IN_READY !== 1'b1) begin tests_failed++; $display("FAIL bp_release_ready: got %b expected 1", IN_READY); end
        step();
        IN_VALID = 1'b0;
        tests_run++;
        if (OUT_VALID !== 1'b1 || OUT_OPCODE !== 8'h22 || OUT_A !== 16'h0022 || OUT_B !== 16'h0011)
            begin tests_failed++; $display("FAIL bp_next: got v=%b op=%h a=%h b=%h expected 1/22/0022/0011", OUT_VALID, OUT_OPCODE, OUT_A, OUT_B); end
        tests_run++;
        if (STALL_CNT !== 16'h0) begin tests_failed++; $display("FAIL bp_stall_cnt: got %h expected 0000", STALL_CNT); end
        step();
        tests_run++;
        if (OUT_VALID !== 1'b0) begin tests_failed++; $display("FAIL bp_drain: got %b expected 0", OUT_VALID); end
    endtask

    task automatic test_waw();
        do_reset();
        step();
        issue(8'h70, 5'd0, 5'd0, 5'd7, 1'b1);
        step();
        issue(8'h77, 5'd0, 5'd0, 5'd7, 1'b1);
        #1;
        tests_run++;
        if (IN_READY !== 1'b0) begin tests_failed++; $display("FAIL waw_stall_ready: got %b expected 0", IN_READY); end
        step();
        tests_run++;
        if (STALL_CNT !== 16'd1 || OUT_OPCODE !== 8'h70)
            begin tests_failed++; $display("FAIL waw_stall_cnt: got stall=%h op=%h expected 0001/70", STALL_CNT, OUT_OPCODE); end
        WB_WE = 1'b1; WB_ADDR = 5'd7; WB_DATA = 16'h0777;
        #1;
        tests_run++;
        if (IN_READY !== 1'b1) begin tests_failed++; $display("FAIL waw_clear_ready: got %b expected 1", IN_READY); end
        step();
        WB_WE = 1'b0;
        tests_run++;
        if (OUT_VALID !== 1'b1 || OUT_OPCODE !== 8'h77 || OUT_RD !== 5'd7)
            begin tests_failed++; $display("FAIL waw_accept: got v=%b op=%h rd=%0d expected 1/77/7", OUT_VALID, OUT_OPCODE, OUT_RD); end
        issue(8'h78, 5'd7, 5'd0, 5'd1, 1'b0);
        #1;
        tests_run++;
        if (IN_READY !== 1'b0) begin tests_failed++; $display("FAIL waw_still_pending: got %b expected 0", IN_READY); end
        IN_VALID = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        step();
        OUT_READY = 1'b0;
        issue(8'h55, 5'd3, 5'd4, 5'd5, 1'b1);
        step();
        IN_VALID = 1'b0;
        tests_run++;
        if (OUT_VALID !== 1'b1) begin tests_failed++; $display("FAIL mid_setup: got %b expected 1", OUT_VALID); end
        RST_N = 1'b0;
        #1;
        tests_run++;
        if (OUT_VALID !== 1'b0 || OUT_OPCODE !== 8'h0 || OUT_A !== 16'h0 || OUT_B !== 16'h0 || OUT_RD !== 5'd0 || OUT_WEN !== 1'b0)
            begin tests_failed++; $display("FAIL mid_async_clear: got v=%b op=%h a=%h b=%h rd=%0d wen=%b expected all 0",
                                           OUT_VALID, OUT_OPCODE, OUT_A, OUT_B, OUT_RD, OUT_WEN); end
        RST_N = 1'b1;
        OUT_READY = 1'b1;
        issue(8'h56, 5'd5, 5'd0, 5'd1, 1'b0);
        #1;
        tests_run++;
        if (IN_READY !== 1'b1) begin tests_failed++; $display("FAIL mid_empty_sb: got %b expected 1", IN_READY); end
        step();
        IN_VALID = 1'b0;
        tests_run++;
        if (OUT_VALID !== 1'b1 || OUT_A !== 16'h1234 || STALL_CNT !== 16'h0)
            begin tests_failed++; $display("FAIL mid_after: got v=%b a=%h stall=%h expected 1/1234/0000", OUT_VALID, OUT_A, STALL_CNT); end
    endtask

    task automatic test_saturate();
        do_reset();
        step();
        issue(8'h90, 5'd0, 5'd0, 5'd9, 1'b1);
        step();
        issue(8'h91, 5'd9, 5'd0, 5'd1, 1'b0);
        repeat (65534) step();
        tests_run++;
        if (STALL_CNT !== 16'hFFFE) begin tests_failed++; $display("FAIL sat_near: got %h expected fffe", STALL_CNT); end
        repeat (6) step();
        tests_run++;
        if (STALL_CNT !== 16'hFFFF) begin tests_failed++; $display("FAIL sat_hold: got %h expected ffff", STALL_CNT); end
        IN_VALID = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_raw();
        test_backpressure();
        test_waw();
        test_reset_mid();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
